// File: rtl/utmi_line_arb_pkg.sv
// Shared encodings and derived timing constants for the UTMI line arbiter.
package utmi_line_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RX   = 3'd1,
    ST_TX   = 3'd2,
    ST_WAIT = 3'd3,
    ST_GAP  = 3'd4
  } arb_state_e;

  localparam logic [1:0] LS_SE0 = 2'b00;
  localparam logic [1:0] LS_J   = 2'b01;
  localparam logic [1:0] LS_K   = 2'b10;

  localparam int DEF_CLKS_PER_BIT     = 4;
  localparam int DEF_IPG_BITS         = 2;
  localparam int DEF_RSP_TIMEOUT_BITS = 18;
  localparam int DEF_CNT_W            = 8;

  localparam int IPG_CYCLES = DEF_IPG_BITS * DEF_CLKS_PER_BIT;
  localparam int RSP_CYCLES = DEF_RSP_TIMEOUT_BITS * DEF_CLKS_PER_BIT;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v, input logic en);
    if (en && (v != 8'hFF)) begin
      return v + 8'd1;
    end else begin
      return v;
    end
  endfunction

endpackage

// File: rtl/utmi_arb_timer.sv
// Clearable/loadable saturating up-counter with a terminal-count flag.
module utmi_arb_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         inc,
  input  logic [W-1:0] term,
  output logic         tc
);

  logic [W-1:0] count_r;

  // Clear beats load beats increment; the count never wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= '0;
    end else if (clr) begin
      count_r <= '0;
    end else if (load) begin
      count_r <= load_val;
    end else if (inc && (count_r != {W{1'b1}})) begin
      count_r <= count_r + {{(W-1){1'b0}}, 1'b1};
    end else begin
      count_r <= count_r;
    end
  end

  assign tc = (count_r >= term);

endmodule

// File: rtl/utmi_line_arb.sv
// Half-duplex DP/DM arbiter between the UTMI receive path and one transmitter.
// Define UTMI_ARB_STATS_EN to add saturating rx_err/timeout/defer counters.
module utmi_line_arb
  import utmi_line_arb_pkg::*;
#(
  parameter int CLKS_PER_BIT     = DEF_CLKS_PER_BIT,
  parameter int IPG_BITS         = DEF_IPG_BITS,
  parameter int RSP_TIMEOUT_BITS = DEF_RSP_TIMEOUT_BITS,
  parameter int CNT_W            = DEF_CNT_W
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       RX_active,
  input  logic       RX_error,
  input  logic       eop_detection,
  input  logic [1:0] LineState,
  input  logic       tx_req,
  input  logic       tx_expect_rsp,
  input  logic       tx_last,
  output logic       TX_en,
  output logic       rx_enable,
  output logic       tx_grant,
  output logic       rsp_ok,
  output logic       rsp_timeout,
  output logic       busy,
  output logic [2:0] arb_state
`ifdef UTMI_ARB_STATS_EN
  ,
  output logic [7:0] rx_err_cnt,
  output logic [7:0] timeout_cnt,
  output logic [7:0] defer_cnt
`endif
);

  localparam logic [CNT_W-1:0] GAP_TERM = CNT_W'(IPG_BITS * CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] RSP_TERM = CNT_W'(RSP_TIMEOUT_BITS * CLKS_PER_BIT - 1);

  arb_state_e state_r, state_s;
  logic expect_r, expect_s, eff_expect_s;
  logic grant_s, ok_s, to_s;
  logic tmr_clr_s, tmr_inc_s, tmr_tc_s;
  logic [CNT_W-1:0] tmr_term_s;

  // The requester may still be settling tx_expect_rsp until the grant cycle.
  assign eff_expect_s = tx_grant ? tx_expect_rsp : expect_r;
  assign tmr_term_s   = (state_r == ST_GAP) ? GAP_TERM : RSP_TERM;

  // Next-state and pulse decode.
  always_comb begin
    state_s   = state_r;
    expect_s  = expect_r;
    grant_s   = 1'b0;
    ok_s      = 1'b0;
    to_s      = 1'b0;
    tmr_clr_s = 1'b0;
    tmr_inc_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (RX_active) begin
          state_s = ST_RX;
        end else if (tx_req) begin
          state_s = ST_TX;
          grant_s = 1'b1;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RX: begin
        if (!RX_active || eop_detection || RX_error) begin
          state_s   = ST_GAP;
          tmr_clr_s = 1'b1;
        end else begin
          state_s = ST_RX;
        end
      end
      ST_TX: begin
        expect_s = eff_expect_s;
        if (tx_last) begin
          state_s   = eff_expect_s ? ST_WAIT : ST_GAP;
          tmr_clr_s = 1'b1;
        end else begin
          state_s = ST_TX;
        end
      end
      ST_WAIT: begin
        if (RX_active) begin
          state_s = ST_RX;
          ok_s    = 1'b1;
        end else if (tmr_tc_s) begin
          state_s = ST_IDLE;
          to_s    = 1'b1;
        end else begin
          tmr_inc_s = 1'b1;
        end
      end
      ST_GAP: begin
        // Only an unbroken run of J bit times frees the line.
        if (RX_active) begin
          state_s = ST_RX;
        end else if (LineState != LS_J) begin
          tmr_clr_s = 1'b1;
        end else if (tmr_tc_s) begin
          state_s = ST_IDLE;
        end else begin
          tmr_inc_s = 1'b1;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_r     <= ST_IDLE;
      expect_r    <= 1'b0;
      TX_en       <= 1'b0;
      rx_enable   <= 1'b1;
      tx_grant    <= 1'b0;
      rsp_ok      <= 1'b0;
      rsp_timeout <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state_r     <= state_s;
      expect_r    <= expect_s;
      TX_en       <= (state_s == ST_TX);
      rx_enable   <= (state_s != ST_TX);
      tx_grant    <= grant_s;
      rsp_ok      <= ok_s;
      rsp_timeout <= to_s;
      busy        <= (state_s != ST_IDLE);
    end
  end

  assign arb_state = state_r;

  utmi_arb_timer #(.W(CNT_W)) u_timer (
    .clk      (CLK),
    .rst_n    (RST),
    .clr      (tmr_clr_s),
    .load     (1'b0),
    .load_val ({CNT_W{1'b0}}),
    .inc      (tmr_inc_s),
    .term     (tmr_term_s),
    .tc       (tmr_tc_s)
  );

`ifdef UTMI_ARB_STATS_EN
  // Saturating statistics counters.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      rx_err_cnt  <= 8'd0;
      timeout_cnt <= 8'd0;
      defer_cnt   <= 8'd0;
    end else begin
      rx_err_cnt  <= sat_inc8(rx_err_cnt, RX_error);
      timeout_cnt <= sat_inc8(timeout_cnt, to_s);
      defer_cnt   <= sat_inc8(defer_cnt,
                              tx_req && (state_r != ST_IDLE) && (state_r != ST_TX));
    end
  end
`endif

endmodule

// File: tb/tb_utmi_line_arb.sv
// Scoreboard bench for utmi_line_arb: stimulus queues per-cycle expectations,
// a negedge monitor pops and compares them and flags any unexpected pulse.
module tb_utmi_line_arb;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RX   = 3'd1;
  localparam logic [2:0] S_TX   = 3'd2;
  localparam logic [2:0] S_WAIT = 3'd3;
  localparam logic [2:0] S_GAP  = 3'd4;

  logic CLK = 1'b0;
  logic RST, RX_active, RX_error, eop_detection, tx_req, tx_expect_rsp, tx_last;
  logic [1:0] LineState;
  logic TX_en, rx_enable, tx_grant, rsp_ok, rsp_timeout, busy;
  logic [2:0] arb_state;
`ifdef UTMI_ARB_STATS_EN
  logic [7:0] rx_err_cnt, timeout_cnt, defer_cnt;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    string      tag;
    int         cyc;
    logic [8:0] v;
  } exp_t;
  exp_t exp_q[$];

  utmi_line_arb dut (
    .CLK(CLK), .RST(RST), .RX_active(RX_active), .RX_error(RX_error),
    .eop_detection(eop_detection), .LineState(LineState), .tx_req(tx_req),
    .tx_expect_rsp(tx_expect_rsp), .tx_last(tx_last), .TX_en(TX_en),
    .rx_enable(rx_enable), .tx_grant(tx_grant), .rsp_ok(rsp_ok),
    .rsp_timeout(rsp_timeout), .busy(busy), .arb_state(arb_state)
`ifdef UTMI_ARB_STATS_EN
    , .rx_err_cnt(rx_err_cnt), .timeout_cnt(timeout_cnt), .defer_cnt(defer_cnt)
`endif
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc++;

  // Monitor: compare the queued expectation for this cycle, reject stray pulses.
  always @(negedge CLK) begin
    logic [8:0] act;
    bit matched;
    exp_t e;
    matched = 1'b0;
    act = {arb_state, TX_en, rx_enable, tx_grant, rsp_ok, rsp_timeout, busy};
    if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      e = exp_q.pop_front();
      checks++;
      errors++;
      $display("FAIL %s missed at cycle %0d (now %0d)", e.tag, e.cyc, cyc);
    end
    if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
      e = exp_q.pop_front();
      matched = 1'b1;
      checks++;
      if (act !== e.v) begin
        errors++;
        $display("FAIL %s cycle %0d {st,txen,rxen,gnt,ok,to,busy} got %b_%b expected %b_%b",
                 e.tag, cyc, act[8:6], act[5:0], e.v[8:6], e.v[5:0]);
      end
    end
    if (!matched && (tx_grant || rsp_ok || rsp_timeout)) begin
      checks++;
      errors++;
      $display("FAIL unexpected_pulse cycle %0d gnt/ok/to got %b%b%b expected 000",
               cyc, tx_grant, rsp_ok, rsp_timeout);
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic exp_at(input string tag, input int dc, input logic [2:0] st,
                        input logic txen, input logic rxen, input logic gnt,
                        input logic ok, input logic to, input logic bsy);
    exp_t e;
    e.tag = tag;
    e.cyc = cyc + dc;
    e.v   = {st, txen, rxen, gnt, ok, to, bsy};
    exp_q.push_back(e);
  endtask

  task automatic chk(input string tag, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, act, exp);
    end
  endtask

  initial begin
    RST = 1'b0; RX_active = 1'b0; RX_error = 1'b0; eop_detection = 1'b0;
    tx_req = 1'b0; tx_expect_rsp = 1'b0; tx_last = 1'b0; LineState = 2'b01;
    step(); step();
    exp_at("reset", 0, S_IDLE, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    RST = 1'b1;
    step();

    // Plain TX without response, then 8 J cycles of gap.
    tx_req = 1'b1; tx_expect_rsp = 1'b0;
    exp_at("t1_grant", 1, S_TX, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    step(); tx_req = 1'b0;
    exp_at("t1_tx_hold", 1, S_TX, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(); tx_last = 1'b1;
    exp_at("t1_gap", 1, S_GAP, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    step(); tx_last = 1'b0;
    exp_at("t1_gap_7", 7, S_GAP, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    exp_at("t1_idle", 8, S_IDLE, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (8) step();

    // RX and tx_req together: RX wins, grant only after the gap.
    RX_active = 1'b1; tx_req = 1'b1;
    exp_at("t2_rx_wins", 1, S_RX, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    repeat (3) step();
    RX_active = 1'b0; eop_detection = 1'b1;
    exp_at("t2_gap", 1, S_GAP, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    step(); eop_detection = 1'b0;
    exp_at("t2_idle", 8, S_IDLE, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    exp_at("t2_grant", 9, S_TX, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    repeat (9) step();
    tx_req = 1'b0; tx_last = 1'b1;
    exp_at("t2_last_in_grant", 1, S_GAP, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    step(); tx_last = 1'b0;

    // Gap broken by a K: J,J,J,K then 8 J.
    exp_at("t5_gap_not_8", 8, S_GAP, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    exp_at("t5_gap_11", 11, S_GAP, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    exp_at("t5_idle", 12, S_IDLE, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (3) step();
    LineState = 2'b10;
    step(); LineState = 2'b01;
    repeat (8) step();

    // Expected response arrives 30 cycles after tx_last.
    tx_req = 1'b1; tx_expect_rsp = 1'b1;
    exp_at("t3_grant", 1, S_TX, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    step(); tx_req = 1'b0;
    exp_at("t3_tx_hold", 1, S_TX, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(); tx_last = 1'b1; tx_expect_rsp = 1'b0;
    exp_at("t3_wait", 1, S_WAIT, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    step(); tx_last = 1'b0;
    repeat (29) step();
    RX_active = 1'b1;
    exp_at("t3_rsp_ok", 1, S_RX, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    step();
    exp_at("t3_rx", 1, S_RX, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    step(); RX_active = 1'b0; RX_error = 1'b1;
    exp_at("t3_err_gap", 1, S_GAP, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    step(); RX_error = 1'b0;
    exp_at("t3_idle", 8, S_IDLE, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (8) step();

    // No response: timeout 72 cycles after entering WAIT_RSP, stray pulses ignored.
    tx_req = 1'b1; tx_expect_rsp = 1'b1;
    exp_at("t4_grant", 1, S_TX, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    step(); tx_req = 1'b0; tx_last = 1'b1;
    exp_at("t4_wait", 1, S_WAIT, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    step(); tx_last = 1'b0; tx_expect_rsp = 1'b0;
    exp_at("t4_wait_71", 71, S_WAIT, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    exp_at("t4_timeout", 72, S_IDLE, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    exp_at("t4_after", 73, S_IDLE, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(); eop_detection = 1'b1; tx_last = 1'b1;
    step(); eop_detection = 1'b0; tx_last = 1'b0;
    repeat (71) step();

    // Response on the very last window cycle: rsp_ok wins over timeout.
    tx_req = 1'b1; tx_expect_rsp = 1'b1;
    exp_at("t6_grant", 1, S_TX, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    step(); tx_req = 1'b0; tx_last = 1'b1;
    exp_at("t6_wait", 1, S_WAIT, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    step(); tx_last = 1'b0;
    exp_at("t6_ok_wins", 72, S_RX, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    repeat (71) step();
    RX_active = 1'b1;
    step(); RX_active = 1'b0;
    exp_at("t6_gap", 1, S_GAP, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    step();
    exp_at("t6_idle", 8, S_IDLE, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (8) step();
`ifdef UTMI_ARB_STATS_EN
    chk("stat_rx_err", int'(rx_err_cnt), 1);
    chk("stat_timeout", int'(timeout_cnt), 1);
    chk("stat_defer", int'(defer_cnt), 11);
`endif

    // Asynchronous reset while transmitting.
    tx_req = 1'b1; tx_expect_rsp = 1'b0;
    exp_at("t7_grant", 1, S_TX, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    step(); tx_req = 1'b0;
    @(negedge CLK); #1;
    RST = 1'b0;
    #1;
    chk("async_rst_txen", int'(TX_en), 0);
    chk("async_rst_state", int'(arb_state), 0);
    chk("async_rst_rxen", int'(rx_enable), 1);
    exp_at("t7_in_reset", 1, S_IDLE, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    RST = 1'b1;
    step();
`ifdef UTMI_ARB_STATS_EN
    chk("stat_rst_timeout", int'(timeout_cnt), 0);
    RX_error = 1'b1;
    repeat (300) step();
    RX_error = 1'b0;
    step();
    chk("stat_rx_err_sat", int'(rx_err_cnt), 255);
`endif

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) step();
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain got %0d pending expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/utmi_line_arb.md
Name: utmi_line_arb

Overview:
- Half-duplex line arbiter/sequencer for the UTMI transceiver.
- Shares the single DP/DM pair between the receive path (RX_active, RX_error, eop_detection, LineState) and one transmit requester.
- Drives TX_en and the RX gating enable, enforces the inter-packet gap, and times the turnaround window when a response is expected.
- Sits between the RX/TX datapath tops and the protocol/link layer.

Parameters:
- CLKS_PER_BIT, 4, CLK cycles per USB bit time (matches the RX sample counter).
- IPG_BITS, 2, consecutive idle (J) bit times required before the line is free.
- RSP_TIMEOUT_BITS, 18, bit times to wait for a response after TX ends.
- CNT_W, 8, timer width; must hold RSP_TIMEOUT_BITS*CLKS_PER_BIT.

Ports:
- CLK, input, 1, system clock.
- RST, input, 1, reset; asynchronous, active-low.
- RX_active, input, 1, receive packet in progress.
- RX_error, input, 1, receive error pulse.
- eop_detection, input, 1, receive EOP seen, one-cycle pulse.
- LineState, input, 2, 00=SE0, 01=J, 10=K, 11=SE1.
- tx_req, input, 1, level; held until tx_grant.
- tx_expect_rsp, input, 1, sampled in the tx_grant cycle.
- tx_last, input, 1, pulse; TX engine has finished driving EOP.
- TX_en, output, 1, transmitter owns the line.
- rx_enable, output, 1, receive path enabled.
- tx_grant, output, 1, one-cycle grant pulse.
- rsp_ok, output, 1, pulse; response started inside the window.
- rsp_timeout, output, 1, pulse; no response inside the window.
- busy, output, 1, state is not IDLE.
- arb_state, output, 3, current state encoding.

Behaviour:
- Reset values (while RST low, asynchronous):
  - State = IDLE.
  - TX_en=0, rx_enable=1, all pulses 0, timers 0.
  - Reset asserted mid-TX drops TX_en immediately.
- All outputs are registered.
- States:
  - IDLE=0
  - RX=1
  - TX=2
  - WAIT_RSP=3
  - GAP=4
- IDLE:
  - RX_active=1 goes to RX. RX wins over tx_req asserted in the same cycle.
  - Else tx_req=1: next cycle is TX with tx_grant=1 for exactly that cycle. TX_en=1 and rx_enable=0 from that cycle on. tx_expect_rsp is latched.
  - tx_req dropped before the grant means no grant.
- RX:
  - rx_enable=1.
  - When RX_active falls (eop_detection or RX_error), go to GAP.
  - tx_req is held off.
- TX:
  - TX_en=1.
  - On tx_last: with latched expect, go to WAIT_RSP (timer cleared); otherwise go to GAP.
  - TX_en is 0 from the cycle after tx_last.
  - RX_active is ignored in TX.
- WAIT_RSP:
  - rx_enable=1; timer increments each cycle.
  - RX_active=1 before the timer reaches RSP_TIMEOUT_BITS*CLKS_PER_BIT-1: rsp_ok pulse and go to RX.
  - At the limit: rsp_timeout pulse and go to IDLE.
  - Both in the same cycle: rsp_ok wins.
- GAP:
  - Timer counts consecutive cycles with LineState==01. Any other LineState clears it.
  - At IPG_BITS*CLKS_PER_BIT cycles, go to IDLE. IDLE is first entered 8 cycles after the first J at defaults.
  - RX_active=1 during GAP goes to RX; the gap is restarted afterwards.
- Stray pulses: tx_last outside TX is ignored; eop_detection/RX_error outside RX are ignored.
- The timer saturates and never wraps.

Optional Feature:
- UTMI_ARB_STATS_EN defined adds three outputs, rx_err_cnt[7:0], timeout_cnt[7:0] and defer_cnt[7:0]:
  - rx_err_cnt counts RX_error pulses.
  - timeout_cnt counts rsp_timeout pulses.
  - defer_cnt counts cycles with tx_req high while not in IDLE/TX.
  - All three saturate at 255 and reset to 0.
- Undefined: these ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package/header holds:
  - state encodings;
  - LineState codes (SE0, J, K);
  - derived constants IPG_CYCLES and RSP_CYCLES.
- One natural sub-module, utmi_arb_timer: loadable/clearable saturating counter with terminal-count flag, reused for the gap and response timing.

Test Plan:
- tx_req high in IDLE, tx_expect_rsp=0 -> tx_grant pulses 1 cycle later, TX_en=1, rx_enable=0. tx_last pulse -> GAP. LineState=J for 8 cycles -> IDLE, busy=0.
- RX_active and tx_req rise in the same cycle -> state RX, no tx_grant. RX_active falls -> GAP, 8 J cycles -> grant issued.
- TX with expect=1, RX_active rises 30 cycles after tx_last -> rsp_ok pulse, state RX, no rsp_timeout.
- TX with expect=1, no RX_active -> rsp_timeout pulse exactly 72 cycles after entering WAIT_RSP, state IDLE.
- GAP with LineState J,J,J,K,J... -> counter restarts at K; IDLE is entered only after 8 consecutive J cycles.
- Reset (RST=0) asserted while TX_en=1 -> TX_en=0 asynchronously, state IDLE. With UTMI_ARB_STATS_EN, 300 RX_error pulses -> rx_err_cnt=255.
